// File: rtl/aes128_ctr_seq_if.sv
// Block stream bundle for the aes128 CTR sequencer: one input lane, one result lane.
// A beat transfers on any rising clk edge where valid and ready are both high; a source
// holds valid, data and last stable until that edge, and ready may depend on state only.
interface aes128_ctr_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/aes128_ctr_seq.sv
// CTR-mode sequencer in front of the aes128 core: one core operation per accepted block,
// key and counter held stable while the core works, counter stepped after each result.
module aes128_ctr_seq #(
    parameter int CTR_WIDTH = 128,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dir,
    input  logic [127:0]         key,
    input  logic [127:0]         iv,
    aes128_ctr_seq_if.slave      stream,
    output logic                 busy,
    output logic                 err,
    output logic [15:0]          blk_cnt,
    output logic                 core_cipher_en,
    output logic                 core_decipher_en,
    output logic                 core_chain_en,
    output logic [127:0]         core_data_in,
    output logic [127:0]         core_key,
    output logic [3:0]           core_mode,
    output logic [127:0]         core_init_vector,
    output logic [15:0]          core_segment_len,
    input  logic [127:0]         core_data_out,
    input  logic                 core_ready,
    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [127:0] CTR_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                        : ((128'd1 << CTR_WIDTH) - 128'd1);

    state_t            state;
    state_t            state_next;
    logic              dir_q;
    logic              last_q;
    logic              ready_q;
    logic              core_done;
    logic              wd_expired;
    logic [WD_W-1:0]   wd_cnt;
    logic [127:0]      ctr_next;
    logic [127:0]      out_data_q;
    logic              out_last_q;

    assign core_done  = core_ready & ~ready_q;
    // wd_cnt holds the number of cycles elapsed since the ISSUE cycle.
    assign wd_expired = (TIMEOUT > 0) && (wd_cnt >= WD_W'(TIMEOUT - 1));
    // Only the low CTR_WIDTH bits step; the carry out of that field is dropped.
    assign ctr_next   = (core_init_vector & ~CTR_MASK)
                      | ((core_init_vector + 128'd1) & CTR_MASK);

    assign busy             = (state != IDLE);
    assign core_chain_en    = (state != IDLE);
    assign stream.in_ready  = (state == LOAD);
    assign stream.out_valid = (state == OUT);
    assign stream.out_data  = out_data_q;
    assign stream.out_last  = out_last_q;
    assign core_cipher_en   = (state == ISSUE) & ~dir_q;
    assign core_decipher_en = (state == ISSUE) & dir_q;
    assign core_mode        = 4'd4;
    assign core_segment_len = 16'd0;
    assign fsm_state        = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    if (stream.in_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (core_done)       state_next = OUT;
                else if (wd_expired) state_next = IDLE;
            end
            OUT:     if (stream.out_ready) state_next = last_q ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            dir_q            <= 1'b0;
            last_q           <= 1'b0;
            ready_q          <= 1'b0;
            wd_cnt           <= '0;
            err              <= 1'b0;
            blk_cnt          <= 16'd0;
            core_key         <= 128'd0;
            core_init_vector <= 128'd0;
            core_data_in     <= 128'd0;
            out_data_q       <= 128'd0;
            out_last_q       <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= core_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q            <= dir;
                        core_key         <= key;
                        core_init_vector <= iv;
                        blk_cnt          <= 16'd0;
                        err              <= 1'b0;
                    end
                end
                LOAD: begin
                    if (stream.in_valid) begin
                        core_data_in <= stream.in_data;
                        last_q       <= stream.in_last;
                    end
                end
                ISSUE: wd_cnt <= WD_W'(1);
                WAIT: begin
                    if (core_done) begin
                        out_data_q <= core_data_out;
                        out_last_q <= last_q;
                    end else if (wd_expired) begin
                        err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                OUT: begin
                    if (stream.out_ready) begin
                        core_init_vector <= ctr_next;
                        blk_cnt          <= blk_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_ctr_seq.sv
// Directed bench for aes128_ctr_seq: SP800-38A F.5.1/F.5.2 vectors through a behavioural
// core whose keystream table holds E(K, ctr) for the four F.5.1 counter blocks.
module tb_aes128_ctr_seq;

    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] IV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
    localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01;
    localparam logic [127:0] IV3 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02;
    localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4  = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] C3  = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    localparam logic [127:0] C4  = 128'h1e031dda2fbe03d1792170a0f3009cee;
    localparam logic [127:0] DW  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IVB = {96'ha5a5a5a55a5a5a5a0f0f0f0f, 32'hffffffff};
    localparam int LAT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, dir, sel, hang;
    logic         in_valid, in_last, out_ready;
    logic [127:0] key, iv, in_data;
    logic         start_a, start_b;
    int           checks = 0;
    int           errors = 0;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    aes128_ctr_seq_if ia ();
    aes128_ctr_seq_if ib ();
    assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
    assign ia.in_data = in_data;    assign ib.in_data = in_data;
    assign ia.in_last = in_last;    assign ib.in_last = in_last;
    assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

    logic         core_ready;
    logic [127:0] core_data_out;
    logic         a_busy, a_err, a_cen, a_den, a_chain, b_busy, b_err, b_cen, b_den, b_chain;
    logic [15:0]  a_blk, b_blk, a_seg, b_seg;
    logic [127:0] a_din, a_key, a_iv, b_din, b_key, b_iv;
    logic [3:0]   a_mode, b_mode;
    logic [2:0]   a_fsm, b_fsm;

    aes128_ctr_seq #(.CTR_WIDTH(128), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dir(dir), .key(key), .iv(iv), .stream(ia),
        .busy(a_busy), .err(a_err), .blk_cnt(a_blk), .core_cipher_en(a_cen),
        .core_decipher_en(a_den), .core_chain_en(a_chain), .core_data_in(a_din),
        .core_key(a_key), .core_mode(a_mode), .core_init_vector(a_iv),
        .core_segment_len(a_seg), .core_data_out(core_data_out), .core_ready(core_ready),
        .fsm_state(a_fsm)
    );

    aes128_ctr_seq #(.CTR_WIDTH(32), .TIMEOUT(64)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dir(dir), .key(key), .iv(iv), .stream(ib),
        .busy(b_busy), .err(b_err), .blk_cnt(b_blk), .core_cipher_en(b_cen),
        .core_decipher_en(b_den), .core_chain_en(b_chain), .core_data_in(b_din),
        .core_key(b_key), .core_mode(b_mode), .core_init_vector(b_iv),
        .core_segment_len(b_seg), .core_data_out(core_data_out), .core_ready(core_ready),
        .fsm_state(b_fsm)
    );

    // Selected-DUT view used by the driver tasks and the core model.
    logic         s_in_ready, s_out_valid, s_out_last, s_busy, s_err;
    logic         m_cen, m_den, m_chain;
    logic [15:0]  s_blk;
    logic [127:0] s_out_data, m_din, m_key, m_iv;
    assign s_in_ready  = sel ? ib.in_ready  : ia.in_ready;
    assign s_out_valid = sel ? ib.out_valid : ia.out_valid;
    assign s_out_last  = sel ? ib.out_last  : ia.out_last;
    assign s_out_data  = sel ? ib.out_data  : ia.out_data;
    assign s_busy      = sel ? b_busy  : a_busy;
    assign s_err       = sel ? b_err   : a_err;
    assign s_blk       = sel ? b_blk   : a_blk;
    assign m_cen       = sel ? b_cen   : a_cen;
    assign m_den       = sel ? b_den   : a_den;
    assign m_chain     = sel ? b_chain : a_chain;
    assign m_din       = sel ? b_din   : a_din;
    assign m_key       = sel ? b_key   : a_key;
    assign m_iv        = sel ? b_iv    : a_iv;

    function automatic logic [127:0] ks(input logic [127:0] k, input logic [127:0] c);
        if (k == K) begin
            if (c == IV)  return P1 ^ C1;
            if (c == IV1) return P2 ^ C2;
            if (c == IV2) return P3 ^ C3;
            if (c == IV3) return P4 ^ C4;
        end
        return ~c ^ k;
    endfunction

    // ---------------- behavioural aes128 core ----------------
    logic     m_busy;
    int       m_cnt, cipher_cnt, decipher_cnt;
    always @(posedge clk) begin
        if (rst) begin
            core_ready    <= 1'b1;
            core_data_out <= 128'd0;
            m_busy        <= 1'b0;
            m_cnt         <= 0;
            cipher_cnt    <= 0;
            decipher_cnt  <= 0;
        end else begin
            cipher_cnt   <= cipher_cnt + int'(m_cen);
            decipher_cnt <= decipher_cnt + int'(m_den);
            if (hang) begin
                core_ready <= 1'b0;
                m_busy     <= 1'b0;
            end else if (m_cen || m_den) begin
                core_ready <= 1'b0;
                m_busy     <= 1'b1;
                m_cnt      <= LAT;
            end else if (m_busy) begin
                // Result uses the inputs present at completion, so any drift is visible.
                if (m_cnt == 1) begin
                    core_ready    <= 1'b1;
                    core_data_out <= m_din ^ ks(m_key, m_iv);
                    m_busy        <= 1'b0;
                end
                m_cnt <= m_cnt - 1;
            end else begin
                core_ready <= 1'b1;
            end
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctrl"}, {s_busy, s_err, s_in_ready, s_out_valid, s_out_last,
                               m_chain, m_cen, m_den}, 128'd0);
        check({tag, "_blk_cnt"}, s_blk, 128'd0);
        check({tag, "_key"}, m_key, 128'd0);
        check({tag, "_ctr"}, m_iv, 128'd0);
        check({tag, "_data_in"}, m_din, 128'd0);
        check({tag, "_out_data"}, s_out_data, 128'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_session(input logic s, input logic d, input logic [127:0] k,
                                 input logic [127:0] v);
        sel = s; dir = d; key = k; iv = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the ISSUE cycle, after checking the counter and the enable pulse.
    task automatic feed(input logic [127:0] d, input logic l, input logic [127:0] exp_ctr,
                        input logic exp_dir, input string tag);
        int n = 0;
        while (!s_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, s_in_ready, 128'd1);
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        check({tag, "_ctr"}, m_iv, exp_ctr);
        check({tag, "_en"}, {m_cen, m_den}, exp_dir ? 128'd1 : 128'd2);
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!s_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, s_out_valid, 128'd1);
    endtask

    task automatic get(input logic [127:0] exp_d, input logic exp_l, input string tag);
        wait_out(tag);
        check({tag, "_out_data"}, s_out_data, exp_d);
        check({tag, "_out_last"}, s_out_last, 128'(exp_l));
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  cb, db;
        logic ok;
        rst = 1'b1; start = 1'b0; dir = 1'b0; sel = 1'b0; hang = 1'b0;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        key = '0; iv = '0; in_data = '0;
        repeat (3) @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_rel");
        check("core_mode", a_mode, 128'd4);
        check("core_seg_len", a_seg, 128'd0);

        // F.5.1 cipher
        cb = cipher_cnt; db = decipher_cnt;
        start_session(1'b0, 1'b0, K, IV);
        check("enc_busy", {s_busy, m_chain}, 128'd3);
        feed(P1, 1'b0, IV,  1'b0, "enc1"); get(C1, 1'b0, "enc1");
        feed(P2, 1'b0, IV1, 1'b0, "enc2"); get(C2, 1'b0, "enc2");
        feed(P3, 1'b0, IV2, 1'b0, "enc3"); get(C3, 1'b0, "enc3");
        feed(P4, 1'b1, IV3, 1'b0, "enc4"); get(C4, 1'b1, "enc4");
        check("enc_done", {s_busy, m_chain}, 128'd0);
        check("enc_blk_cnt", s_blk, 128'd4);
        check("enc_pulses", 128'(cipher_cnt - cb), 128'd4);
        check("enc_no_dec", 128'(decipher_cnt - db), 128'd0);

        // F.5.2 decipher, started in the first IDLE cycle after the previous session
        cb = cipher_cnt; db = decipher_cnt;
        start_session(1'b0, 1'b1, K, IV);
        feed(C1, 1'b0, IV,  1'b1, "dec1"); get(P1, 1'b0, "dec1");
        feed(C2, 1'b0, IV1, 1'b1, "dec2"); get(P2, 1'b0, "dec2");
        feed(C3, 1'b0, IV2, 1'b1, "dec3"); get(P3, 1'b0, "dec3");
        feed(C4, 1'b1, IV3, 1'b1, "dec4"); get(P4, 1'b1, "dec4");
        check("dec_blk_cnt", s_blk, 128'd4);
        check("dec_pulses", 128'(decipher_cnt - db), 128'd4);
        check("dec_no_enc", 128'(cipher_cnt - cb), 128'd0);

        // Output backpressure on block 1
        cb = cipher_cnt;
        start_session(1'b0, 1'b0, K, IV);
        out_ready = 1'b0;
        feed(P1, 1'b0, IV, 1'b0, "bp1");
        wait_out("bp1_hold");
        ok = 1'b1;
        repeat (5) begin
            if (!(s_out_valid && s_out_data == C1 && !s_in_ready && cipher_cnt - cb == 1))
                ok = 1'b0;
            @(negedge clk);
        end
        check("bp_stable", ok, 128'd1);
        out_ready = 1'b1;
        get(C1, 1'b0, "bp1");
        feed(P2, 1'b1, IV1, 1'b0, "bp2"); get(C2, 1'b1, "bp2");
        check("bp_pulses", 128'(cipher_cnt - cb), 128'd2);

        // Full-width counter wrap
        start_session(1'b0, 1'b0, K, {128{1'b1}});
        feed(DW, 1'b0, {128{1'b1}}, 1'b0, "wrap128_1");
        get(DW ^ ks(K, {128{1'b1}}), 1'b0, "wrap128_1");
        feed(DW, 1'b1, 128'd0, 1'b0, "wrap128_2");
        get(DW ^ ks(K, 128'd0), 1'b1, "wrap128_2");
        check("wrap128_blk_cnt", s_blk, 128'd2);

        // 32-bit counter field wrap, upper bits held
        start_session(1'b1, 1'b0, K, IVB);
        feed(DW, 1'b0, IVB, 1'b0, "wrap32_1");
        get(DW ^ ks(K, IVB), 1'b0, "wrap32_1");
        feed(DW, 1'b1, {IVB[127:32], 32'd0}, 1'b0, "wrap32_2");
        get(DW ^ ks(K, {IVB[127:32], 32'd0}), 1'b1, "wrap32_2");
        sel = 1'b0;

        // Watchdog with the core never ready
        hang = 1'b1;
        @(negedge clk);
        start_session(1'b0, 1'b0, K, IV);
        feed(P1, 1'b0, IV, 1'b0, "wd");
        ok = 1'b1;
        for (int i = 1; i < 64; i++) begin
            @(negedge clk);
            if (!(s_busy && !s_err && !s_out_valid)) ok = 1'b0;
        end
        check("wd_before_64", ok, 128'd1);
        @(negedge clk);
        check("wd_at_64", {s_err, s_busy, s_out_valid}, 128'd4);
        hang = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_err_sticky", s_err, 128'd1);
        start_session(1'b0, 1'b0, K, IV);
        check("wd_err_cleared", s_err, 128'd0);
        feed(P1, 1'b1, IV, 1'b0, "wd_next"); get(C1, 1'b1, "wd_next");

        // start ignored in WAIT, then rst in WAIT
        start_session(1'b0, 1'b0, K, IV);
        feed(P1, 1'b0, IV, 1'b0, "abort");
        @(negedge clk);
        start_session(1'b0, 1'b1, 128'd0, 128'd0);
        check("abort_state", a_fsm, 128'd3);
        check("abort_key", m_key, K);
        check("abort_ctr", m_iv, IV);
        check("abort_en", {m_cen, m_den, s_busy}, 128'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_wait");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        start_session(1'b0, 1'b0, K, IV);
        feed(P1, 1'b1, IV, 1'b0, "post_rst"); get(C1, 1'b1, "post_rst");
        check("post_rst_blk_cnt", s_blk, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
